// File: rtl/rcc_cfg_switch_seq_if.sv
// RCC config-switch sequencer bus.
// Test/regfile side is master; sequencer is slave.
interface rcc_cfg_switch_seq_if;
   logic test_req;
   logic cfg_update;
   logic atspeed_mode;
   logic clk_gate_en;
   logic cfg_load;
   logic busy;
   logic done;

   modport master (
      output test_req,
      output cfg_update,
      input  atspeed_mode,
      input  clk_gate_en,
      input  cfg_load,
      input  busy,
      input  done
   );

   modport slave (
      input  test_req,
      input  cfg_update,
      output atspeed_mode,
      output clk_gate_en,
      output cfg_load,
      output busy,
      output done
   );
endinterface

// File: rtl/rcc_cfg_switch_seq.sv
// RCC config mux sequencer: gate, wait, switch/load,
// settle, ungate, so no downstream clock sees a mid-cycle change.
module rcc_cfg_switch_seq #(
   parameter int unsigned GATE_WAIT   = 4,
   parameter int unsigned SETTLE_WAIT = 8,
   parameter int unsigned CNT_W       = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   rcc_cfg_switch_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GATE,
      S_SWITCH,
      S_SETTLE,
      S_UNGATE
   } state_t;

   localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_WAIT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_WAIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, sync2_q;
   logic             pend_q, pend_d;
   logic             mode_q, mode_d;
   logic             gate_en_q;
   logic             pend_clr;
   logic             load;
   logic             done;

   // Two-flop synchroniser for the asynchronous test request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bus.test_req;
         sync2_q <= sync1_q;
      end
   end

   // Sticky pending-update flag; a new update beats the clear
   assign pend_d = bus.cfg_update | (pend_q & ~pend_clr);

   // Sequence FSM: next state, counter, mode and strobes
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      pend_clr = 1'b0;
      load     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if ((sync2_q != mode_q) || pend_q) begin
               state_d = S_GATE;
               cnt_d   = GATE_LD;
            end
         end
         S_GATE: begin
            if (cnt_q == '0) state_d = S_SWITCH;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         S_SWITCH: begin
            mode_d   = sync2_q;
            load     = pend_q;
            pend_clr = 1'b1;
            state_d  = S_SETTLE;
            cnt_d    = SETTLE_LD;
         end
         S_SETTLE: begin
            if (cnt_q == '0) state_d = S_UNGATE;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         S_UNGATE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counter, mode and pending-flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
      end
   end

   // Gate enable from its own flop so it cannot glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gate_en_q <= 1'b1;
      else        gate_en_q <= (state_d == S_IDLE);
   end

   assign bus.atspeed_mode = mode_q;
   assign bus.clk_gate_en  = gate_en_q;
   assign bus.cfg_load     = load;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.done         = done;

endmodule

// File: tb/tb_rcc_cfg_switch_seq.sv
// Bench for rcc_cfg_switch_seq: timestamp-based reference
// model feeds expectation queues drained by a negedge monitor.
module tb_rcc_cfg_switch_seq;

   localparam int G = 4;
   localparam int S = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   rcc_cfg_switch_seq_if bus ();

   rcc_cfg_switch_seq #(
      .GATE_WAIT   (G),
      .SETTLE_WAIT (S),
      .CNT_W       (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int   cyc;
      logic mode;
   } done_t;

   done_t done_q[$];
   int    load_q[$];

   // Reference model state: sequence = G+S+2 busy cycles
   // starting at edge st; switch at st+G, done at st+G+S+1.
   int cyc    = 0;
   int st     = 0;
   bit act    = 0;
   bit m_mode = 0;
   bit m_pend = 0;
   bit sw_mode = 0;
   bit tr_prev = 0;
   bit rs     = 0;
   bit tr_s, cu_s;

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, got, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         act     = 0;
         m_mode  = 0;
         m_pend  = 0;
         tr_prev = 0;
         rs      = 0;
         done_q.delete();
         load_q.delete();
      end else begin
         done_t d;
         tr_s = bus.test_req;
         cu_s = bus.cfg_update;
         cyc++;
         if (!act) begin
            if ((rs != m_mode) || m_pend) begin
               act = 1;
               st  = cyc;
            end
         end else if (cyc == st + G + S + 2) begin
            act = 0;
         end
         if (act && cyc == st + G) begin
            if (m_pend | cu_s) load_q.push_back(cyc);
            sw_mode = tr_prev;
         end
         if (act && cyc == st + G + 1) begin
            m_mode = sw_mode;
            m_pend = cu_s;
         end else begin
            m_pend = m_pend | cu_s;
         end
         if (act && cyc == st + G + S + 1) begin
            d.cyc  = cyc;
            d.mode = m_mode;
            done_q.push_back(d);
         end
         rs      = tr_prev;
         tr_prev = tr_s;
      end
   end

   initial forever begin
      bit exp_d, exp_l;
      done_t d;
      @(negedge clk);
      chk("busy_gate_mode",
          {29'b0, bus.busy, bus.clk_gate_en, bus.atspeed_mode},
          {29'b0, act, ~act, m_mode});
      exp_d = (done_q.size() > 0) && (done_q[0].cyc == cyc);
      chk("done", {31'b0, bus.done}, {31'b0, exp_d});
      if (exp_d) begin
         d = done_q.pop_front();
         chk("done_mode", {31'b0, bus.atspeed_mode}, {31'b0, d.mode});
      end
      exp_l = (load_q.size() > 0) && (load_q[0] == cyc);
      chk("cfg_load", {31'b0, bus.cfg_load}, {31'b0, exp_l});
      if (exp_l) void'(load_q.pop_front());
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse_cfg();
      bus.cfg_update = 1'b1;
      step(1);
      bus.cfg_update = 1'b0;
   endtask

   initial begin
      int w;
      bus.test_req   = 1'b0;
      bus.cfg_update = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(20);

      bus.test_req = 1'b1;
      step(25);
      bus.test_req = 1'b0;
      step(25);

      pulse_cfg();
      step(25);

      bus.test_req = 1'b1;
      step(2);
      pulse_cfg();
      step(25);

      bus.test_req = 1'b0;
      step(9);
      pulse_cfg();
      step(40);

      bus.test_req = 1'b1;
      w = 0;
      while (bus.atspeed_mode !== 1'b1 && w < 40) begin
         step(1);
         w++;
      end
      step(2);
      chk("pre_rst_mode", {31'b0, bus.atspeed_mode}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_mode", {31'b0, bus.atspeed_mode}, 32'd0);
      chk("rst_async_gate", {31'b0, bus.clk_gate_en}, 32'd1);
      chk("rst_async_busy", {31'b0, bus.busy}, 32'd0);
      step(2);
      rst_n = 1'b1;
      step(2);
      chk("rel_edge2_busy", {31'b0, bus.busy}, 32'd0);
      step(1);
      chk("rel_edge3_busy", {31'b0, bus.busy}, 32'd1);
      step(30);

      repeat (1500) begin
         if ($urandom_range(0, 39) == 0) bus.test_req = ~bus.test_req;
         bus.cfg_update = ($urandom_range(0, 24) == 0);
         step(1);
      end
      bus.cfg_update = 1'b0;
      bus.test_req   = 1'b0;
      step(60);

      chk("done_q_empty", done_q.size(), 32'd0);
      chk("load_q_empty", load_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
